// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/almost-empty thresholds
//
// Transmit queue feeding arbitro1. Supplies empty / almost_empty / almost_full
// for the arbiter and returns registered read data one cycle after an accepted pop.
//
// Optional feature macro: FIFO_ERR_STICKY_EN
//   defined   : error latches on the first overflow/underflow until reset or init
//   undefined : error is a one-cycle pulse per rejected push/pop
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   init          latch thresholds and flush; FIFO idle while high
//   umbral_alto   almost_full threshold (0 selects DEPTH)
//   umbral_bajo   almost_empty threshold (>=DEPTH selects DEPTH-1)
//   push, data_in write request and data
//   pop           read request
//   data_out      registered read data
//   data_valid    data_out was updated by a pop accepted on the previous edge
//   full, empty, almost_full, almost_empty   occupancy flags (from registered count)
//   count         occupancy
//   error         overflow/underflow indication

module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THR_HI_RST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] THR_LO_RST = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   thr_hi;
  logic [ADDR_W:0]   thr_lo;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              push_acc;
  logic              pop_acc;
  logic              rejected;
  logic [ADDR_W:0]   next_count;

  // Flags come straight from the registered count, so they trail the
  // push/pop edge by one cycle.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= thr_hi);
  assign almost_empty = (count != '0) && (count <= thr_lo);

  // Push/pop only take effect once the queue has left INIT and init is low.
  assign run = (state != S_INIT) && !init;

  // A push into a full FIFO still goes through when a pop frees the slot on
  // the same edge; the read below sees the old word because mem is written
  // with a non-blocking assignment.
  assign pop_acc  = run && pop && !empty;
  assign push_acc = run && push && (!full || pop);
  assign rejected = run && ((push && !push_acc) || (pop && !pop_acc));

  assign next_count = count + {{ADDR_W{1'b0}}, push_acc} - {{ADDR_W{1'b0}}, pop_acc};

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      thr_hi     <= THR_HI_RST;
      thr_lo     <= THR_LO_RST;
    end else if (init) begin
      // Flush and (re)latch thresholds every cycle init is held.
      state      <= S_INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      thr_hi     <= (umbral_alto == '0) ? FULL_CNT : umbral_alto;
      thr_lo     <= (umbral_bajo >= FULL_CNT) ? THR_HI_RST : umbral_bajo;
    end else begin
      case (state)
        S_INIT: begin
          state      <= S_IDLE;
          data_valid <= 1'b0;
        end
        S_IDLE, S_ACTIVE: begin
          if (push_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (pop_acc) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
          end
          data_valid <= pop_acc;
          count      <= next_count;
          state      <= (next_count == '0) ? S_IDLE : S_ACTIVE;
`ifdef FIFO_ERR_STICKY_EN
          error <= error | rejected;
`else
          error <= rejected;
`endif
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - self-checking bench for fifo_umbral against a queue model
//
// Drives directed scenarios followed by randomized push/pop/init/reset traffic.
// A queue-based model predicts every output each cycle; a few literal
// expectations pin the model on the directed scenarios.
//
// Ports of the DUT are all driven/observed from this module.

module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       error;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [5:0] m_q[$];
  int         m_thr_hi;
  int         m_thr_lo;
  bit         m_running;
  logic [5:0] m_dout;
  bit         m_dv;
  bit         m_err;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the queue's rules rather than pointers.
  task automatic model_update();
    int  n;
    bit  pa;
    bit  ua;
    bit  rej;
    if (reset) begin
      m_q.delete();
      m_thr_hi  = 7;
      m_thr_lo  = 1;
      m_running = 0;
      m_dout    = '0;
      m_dv      = 0;
      m_err     = 0;
    end else if (init) begin
      m_q.delete();
      m_thr_hi  = (umbral_alto == 0) ? 8 : int'(umbral_alto);
      m_thr_lo  = (umbral_bajo >= 8) ? 7 : int'(umbral_bajo);
      m_running = 0;
      m_dout    = '0;
      m_dv      = 0;
      m_err     = 0;
    end else if (!m_running) begin
      m_running = 1;
      m_dv      = 0;
    end else begin
      n   = m_q.size();
      pa  = pop && (n > 0);
      ua  = push && ((n < 8) || pop);
      rej = (push && !ua) || (pop && !pa);
      if (pa) m_dout = m_q.pop_front();
      if (ua) m_q.push_back(data_in);
      m_dv = pa;
`ifdef FIFO_ERR_STICKY_EN
      m_err = m_err | rej;
`else
      m_err = rej;
`endif
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_q.size();
    check("count",        int'(count),        n);
    check("empty",        int'(empty),        int'(n == 0));
    check("full",         int'(full),         int'(n == 8));
    check("almost_full",  int'(almost_full),  int'(n >= m_thr_hi));
    check("almost_empty", int'(almost_empty), int'(n >= 1 && n <= m_thr_lo));
    check("data_valid",   int'(data_valid),   int'(m_dv));
    check("data_out",     int'(data_out),     int'(m_dout));
    check("error",        int'(error),        int'(m_err));
  endtask

  task automatic step(input bit r, input bit i, input bit pu, input bit po,
                      input logic [5:0] d, input logic [3:0] ua, input logic [3:0] ub);
    reset       = r;
    init        = i;
    push        = pu;
    pop         = po;
    data_in     = d;
    umbral_alto = ua;
    umbral_bajo = ub;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 6'h00, 4'd0, 4'd0);
  endtask

  initial begin
    // 1: reset, program thresholds 6/2, leave INIT
    step(1, 0, 0, 0, 6'h00, 4'd0, 4'd0);
    check("rst_empty",       int'(empty),        1);
    check("rst_almost_full", int'(almost_full),  0);
    check("rst_almost_emp",  int'(almost_empty), 0);
    step(1, 0, 0, 0, 6'h00, 4'd0, 4'd0);
    step(0, 1, 0, 0, 6'h00, 4'd6, 4'd2);
    step(0, 0, 0, 0, 6'h00, 4'd6, 4'd2);
    check("t1_count", int'(count), 0);
    check("t1_empty", int'(empty), 1);
    check("t1_error", int'(error), 0);

    // 2: push 1..8, then overflow
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 0, 6'(k), 4'd0, 4'd0);
      check("t2_count",        int'(count),        k);
      check("t2_almost_empty", int'(almost_empty), int'(k <= 2));
      check("t2_almost_full",  int'(almost_full),  int'(k >= 6));
      check("t2_full",         int'(full),         int'(k == 8));
    end
    step(0, 0, 1, 0, 6'h2A, 4'd0, 4'd0);
    check("t2_ovf_count", int'(count), 8);
    check("t2_ovf_error", int'(error), 1);

    // 3: pop 8 from full, then underflow
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 1, 6'h00, 4'd0, 4'd0);
      check("t3_data",  int'(data_out),   k);
      check("t3_valid", int'(data_valid), 1);
    end
    check("t3_empty", int'(empty), 1);
    step(0, 0, 0, 1, 6'h00, 4'd0, 4'd0);
    check("t3_unf_valid", int'(data_valid), 0);
    check("t3_unf_data",  int'(data_out),   8);
    check("t3_unf_error", int'(error),      1);

    // 4: hold count=4, push+pop together across pointer wrap (fresh init clears sticky error)
    step(0, 1, 0, 0, 6'h00, 4'd6, 4'd2);
    idle_step();
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 6'($urandom_range(63)), 4'd0, 4'd0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 1, 1, 6'($urandom_range(63)), 4'd0, 4'd0);
      check("t4_count", int'(count), 4);
      check("t4_error", int'(error), 0);
    end

    // 5: at full, push 0x3F with pop
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 6'(k + 16), 4'd0, 4'd0);
    check("t5_full", int'(full), 1);
    step(0, 0, 1, 1, 6'h3F, 4'd0, 4'd0);
    check("t5_count", int'(count), 8);
    check("t5_error", int'(error), 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 6'h00, 4'd0, 4'd0);
    check("t5_late_word", int'(data_out), 'h3F);

    // 6: init mid-operation with count=5 after an underflow; alto=0, bajo=9
    step(0, 0, 0, 1, 6'h00, 4'd0, 4'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 6'(k + 40), 4'd0, 4'd0);
    check("t6_pre_count", int'(count), 5);
    step(0, 1, 1, 1, 6'h11, 4'd0, 4'd9);
    step(0, 1, 0, 0, 6'h00, 4'd0, 4'd9);
    check("t6_count", int'(count), 0);
    check("t6_empty", int'(empty), 1);
    check("t6_error", int'(error), 0);
    idle_step();
    for (int k = 0; k < 7; k++) step(0, 0, 1, 0, 6'(k), 4'd0, 4'd0);
    check("t6_ae_at7", int'(almost_empty), 1);
    check("t6_af_at7", int'(almost_full),  0);
    step(0, 0, 1, 0, 6'h07, 4'd0, 4'd0);
    check("t6_ae_at8", int'(almost_empty), 0);
    check("t6_af_at8", int'(almost_full),  1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(149) == 0), ($urandom_range(39) == 0),
           ($urandom_range(99) < 55), ($urandom_range(99) < 45),
           6'($urandom_range(63)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
